alien_zigzag_ctrl: RTL and testbench

ALIEN_ZIGZAG_CTRL -- requirements
Module: alien_zigzag_ctrl

---
 rtl/alien_zigzag_ctrl.sv | 140 ++++++++++++++
 tb/tb_alien_zigzag_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alien_zigzag_ctrl.sv
// Alien formation zigzag controller: marches the formation sideways on a tick timebase,
// steps down at each wall, speeds up as aliens die and freezes on victory or defeat.
module alien_zigzag_ctrl #(
   parameter int PERIOD_INIT = 50,
   parameter int PERIOD_MIN  = 4,
   parameter int PERIOD_DEC  = 1,
   parameter int DOWN_STEPS  = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       canLeft,
   input  logic       canRight,
   input  logic       killingAlien,
   input  logic       victory,
   input  logic       defeat,
   output logic [2:0] motion,
   output logic [7:0] period,
   output logic       halted
);

   typedef enum logic [1:0] {
      MOVE_RIGHT,
      MOVE_LEFT,
      DESCEND,
      HALT
   } stateT;

   localparam logic [2:0] MOT_NONE  = 3'd0;
   localparam logic [2:0] MOT_LEFT  = 3'd1;
   localparam logic [2:0] MOT_RIGHT = 3'd2;
   localparam logic [2:0] MOT_DOWN  = 3'd3;

   localparam logic [7:0] INIT_PERIOD  = 8'(PERIOD_INIT);
   localparam logic [8:0] MIN_PERIOD   = 9'(PERIOD_MIN);
   localparam logic [8:0] DEC_PERIOD   = 9'(PERIOD_DEC);
   localparam logic [3:0] DESCEND_LOAD = 4'(DOWN_STEPS - 1);
   localparam stateT      AFTER_RIGHT  = (DOWN_STEPS == 1) ? MOVE_LEFT : DESCEND;
   localparam stateT      AFTER_LEFT   = (DOWN_STEPS == 1) ? MOVE_RIGHT : DESCEND;

   stateT       state, stateNext;
   logic        nextDir, nextDirNext;
   logic [7:0]  counter, counterNext;
   logic [3:0]  descCnt, descCntNext;
   logic [7:0]  periodNext;
   logic [2:0]  motionNext;
   logic [8:0]  periodWide;
   logic        stepEvent;

   assign periodWide = {1'b0, period};
   // Comparing with >= lets a period that shrinks below the running count fire on the next tick.
   assign stepEvent  = tick && (counter >= (period - 8'd1));
   assign halted     = (state == HALT);

   // State register and all controller bookkeeping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= MOVE_RIGHT;
         nextDir <= 1'b0;
         counter <= 8'd0;
         descCnt <= 4'd0;
         period  <= INIT_PERIOD;
         motion  <= MOT_NONE;
      end else begin
         state   <= stateNext;
         nextDir <= nextDirNext;
         counter <= counterNext;
         descCnt <= descCntNext;
         period  <= periodNext;
         motion  <= motionNext;
      end
   end

   // Next-state logic: halt requests win over everything, the kill update uses the
   // period seen by this cycle's step decision, and walls are only looked at on a step.
   always_comb begin
      stateNext   = state;
      nextDirNext = nextDir;
      counterNext = counter;
      descCntNext = descCnt;
      periodNext  = period;
      motionNext  = MOT_NONE;

      if (state != HALT) begin
         if (victory || defeat) begin
            stateNext = HALT;
         end else begin
            if (killingAlien) begin
               if (periodWide >= (MIN_PERIOD + DEC_PERIOD)) begin
                  periodNext = 8'(periodWide - DEC_PERIOD);
               end else begin
                  periodNext = 8'(MIN_PERIOD);
               end
            end

            if (tick) begin
               if (stepEvent) begin
                  counterNext = 8'd0;
                  unique case (state)
                     MOVE_RIGHT: begin
                        if (canRight) begin
                           motionNext = MOT_RIGHT;
                        end else begin
                           motionNext  = MOT_DOWN;
                           nextDirNext = 1'b1;
                           descCntNext = DESCEND_LOAD;
                           stateNext   = AFTER_RIGHT;
                        end
                     end
                     MOVE_LEFT: begin
                        if (canLeft) begin
                           motionNext = MOT_LEFT;
                        end else begin
                           motionNext  = MOT_DOWN;
                           nextDirNext = 1'b0;
                           descCntNext = DESCEND_LOAD;
                           stateNext   = AFTER_LEFT;
                        end
                     end
                     DESCEND: begin
                        motionNext  = MOT_DOWN;
                        descCntNext = descCnt - 4'd1;
                        if (descCnt <= 4'd1) begin
                           descCntNext = 4'd0;
                           stateNext   = nextDir ? MOVE_LEFT : MOVE_RIGHT;
                        end
                     end
                     default: begin
                        motionNext = MOT_NONE;
                     end
                  endcase
               end else begin
                  counterNext = counter + 8'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_alien_zigzag_ctrl.sv
// Self-checking bench for alien_zigzag_ctrl: two differently parameterised instances share
// stimulus and are compared every cycle against a step-counting behavioural model.
module tb_alien_zigzag_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic tick = 1'b0, canLeft = 1'b0, canRight = 1'b0;
   logic killingAlien = 1'b0, victory = 1'b0, defeat = 1'b0;

   logic [2:0] motion [2];
   logic [7:0] period [2];
   logic       halted [2];

   int checks = 0;
   int failures = 0;

   int pInit [2] = '{6, 4};
   int pMin  [2] = '{4, 2};
   int pDec  [2] = '{1, 3};
   int pDown [2] = '{2, 1};

   // Model: heading (0 right, 1 left), pending down steps, ticks counted, current period.
   int mPer [2], mCnt [2], mDir [2], mDowns [2], mHalt [2], mMotion [2];

   always #5 clk = ~clk;

   alien_zigzag_ctrl #(.PERIOD_INIT(6), .PERIOD_MIN(4), .PERIOD_DEC(1), .DOWN_STEPS(2)) dutA (
      .clk(clk), .reset(reset), .tick(tick), .canLeft(canLeft), .canRight(canRight),
      .killingAlien(killingAlien), .victory(victory), .defeat(defeat),
      .motion(motion[0]), .period(period[0]), .halted(halted[0]));

   alien_zigzag_ctrl #(.PERIOD_INIT(4), .PERIOD_MIN(2), .PERIOD_DEC(3), .DOWN_STEPS(1)) dutB (
      .clk(clk), .reset(reset), .tick(tick), .canLeft(canLeft), .canRight(canRight),
      .killingAlien(killingAlien), .victory(victory), .defeat(defeat),
      .motion(motion[1]), .period(period[1]), .halted(halted[1]));

   // A wall turns into a batch of down steps plus an immediate change of heading.
   always @(posedge clk or negedge reset) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset) begin
            mPer[i] = pInit[i]; mCnt[i] = 0; mDir[i] = 0; mDowns[i] = 0; mHalt[i] = 0; mMotion[i] = 0;
         end else begin
            mMotion[i] = 0;
            if (mHalt[i] == 0) begin
               if (victory || defeat) begin
                  mHalt[i] = 1;
               end else begin
                  if (tick) begin
                     if (mCnt[i] + 1 >= mPer[i]) begin
                        mCnt[i] = 0;
                        if (mDowns[i] > 0) begin
                           mMotion[i] = 3; mDowns[i] = mDowns[i] - 1;
                        end else if (mDir[i] == 0 && canRight) begin
                           mMotion[i] = 2;
                        end else if (mDir[i] == 1 && canLeft) begin
                           mMotion[i] = 1;
                        end else begin
                           mMotion[i] = 3; mDowns[i] = pDown[i] - 1; mDir[i] = 1 - mDir[i];
                        end
                     end else begin
                        mCnt[i] = mCnt[i] + 1;
                     end
                  end
                  if (killingAlien)
                     mPer[i] = (mPer[i] - pDec[i] > pMin[i]) ? mPer[i] - pDec[i] : pMin[i];
               end
            end
         end
      end
   end

   task automatic applyStimulus(input logic t, input logic l, input logic r,
                                input logic k, input logic v, input logic d);
      tick = t; canLeft = l; canRight = r; killingAlien = k; victory = v; defeat = d;
   endtask

   task automatic applyReset();
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++; if (motion[i] !== 3'd0) begin failures++; $display("[TB] FAIL reset.motion dut%0d got=%0d exp=0", i, motion[i]); end
         checks++; if (period[i] !== 8'(pInit[i])) begin failures++; $display("[TB] FAIL reset.period dut%0d got=%0d exp=%0d", i, period[i], pInit[i]); end
         checks++; if (halted[i] !== 1'b0) begin failures++; $display("[TB] FAIL reset.halted dut%0d got=%0b exp=0", i, halted[i]); end
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_march();
      int lastPulse = -1;
      applyReset();
      applyStimulus(1, 1, 1, 0, 0, 0);
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            checks++; if (motion[i] !== 3'(mMotion[i])) begin failures++; $display("[TB] FAIL march.motion dut%0d cyc%0d got=%0d exp=%0d", i, c, motion[i], mMotion[i]); end
            checks++; if (period[i] !== 8'(mPer[i])) begin failures++; $display("[TB] FAIL march.period dut%0d got=%0d exp=%0d", i, period[i], mPer[i]); end
         end
         if (motion[1] == 3'd2) begin
            checks++;
            if ((lastPulse < 0 && c != 4) || (lastPulse >= 0 && c - lastPulse != 4)) begin
               failures++; $display("[TB] FAIL march.spacing cyc%0d got_prev=%0d exp_gap=4", c, lastPulse);
            end
            lastPulse = c;
         end
      end
   endtask

   task automatic test_wall_descend();
      applyReset();
      applyStimulus(1, 1, 0, 0, 0, 0);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            checks++; if (motion[i] !== 3'(mMotion[i])) begin failures++; $display("[TB] FAIL descend.motion dut%0d cyc%0d got=%0d exp=%0d", i, c, motion[i], mMotion[i]); end
         end
         if (c == 6) canRight = 1'b1;
      end
   endtask

   task automatic test_both_walls();
      int downs = 0;
      applyReset();
      applyStimulus(1, 0, 0, 0, 0, 0);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            checks++; if (motion[i] == 3'd1 || motion[i] == 3'd2) begin failures++; $display("[TB] FAIL walls.sideways dut%0d cyc%0d got=%0d exp=0or3", i, c, motion[i]); end
            checks++; if (motion[i] !== 3'(mMotion[i])) begin failures++; $display("[TB] FAIL walls.motion dut%0d cyc%0d got=%0d exp=%0d", i, c, motion[i], mMotion[i]); end
         end
         if (motion[0] == 3'd3) downs++;
      end
      checks++; if (downs != 6) begin failures++; $display("[TB] FAIL walls.downcount got=%0d exp=6", downs); end
   endtask

   task automatic test_kills();
      int expA [5] = '{5, 4, 4, 4, 4};
      int fired = 0;
      applyReset();
      for (int k = 0; k < 5; k++) begin
         applyStimulus(0, 1, 1, 1, 0, 0);
         @(negedge clk);
         checks++; if (period[0] !== 8'(expA[k])) begin failures++; $display("[TB] FAIL kill.periodA k%0d got=%0d exp=%0d", k, period[0], expA[k]); end
         checks++; if (period[1] !== 8'd2) begin failures++; $display("[TB] FAIL kill.periodB k%0d got=%0d exp=2", k, period[1]); end
      end
      applyReset();
      applyStimulus(1, 1, 1, 0, 0, 0);
      for (int c = 1; c <= 30; c++) begin
         killingAlien = (fired == 0 && mCnt[0] + 1 >= mPer[0] && c > 2);
         if (killingAlien) fired = 1;
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            checks++; if (motion[i] !== 3'(mMotion[i])) begin failures++; $display("[TB] FAIL killstep.motion dut%0d cyc%0d got=%0d exp=%0d", i, c, motion[i], mMotion[i]); end
            checks++; if (period[i] !== 8'(mPer[i])) begin failures++; $display("[TB] FAIL killstep.period dut%0d got=%0d exp=%0d", i, period[i], mPer[i]); end
         end
      end
   endtask

   task automatic test_random();
      applyReset();
      for (int c = 1; c <= 400; c++) begin
         applyStimulus(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 3) != 0,
                       ($urandom % 12) == 0, 0, 0);
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            checks++; if (motion[i] !== 3'(mMotion[i])) begin failures++; $display("[TB] FAIL random.motion dut%0d cyc%0d got=%0d exp=%0d", i, c, motion[i], mMotion[i]); end
            checks++; if (period[i] !== 8'(mPer[i])) begin failures++; $display("[TB] FAIL random.period dut%0d cyc%0d got=%0d exp=%0d", i, c, period[i], mPer[i]); end
            checks++; if (halted[i] !== 1'(mHalt[i])) begin failures++; $display("[TB] FAIL random.halted dut%0d got=%0b exp=%0d", i, halted[i], mHalt[i]); end
         end
      end
   endtask

   task automatic test_halt();
      int found = 0;
      logic [7:0] frozenA;
      applyReset();
      applyStimulus(1, 1, 1, 1, 0, 0);
      for (int c = 0; c < 20 && found == 0; c++) begin
         @(negedge clk);
         killingAlien = 1'b0;
         if (mCnt[0] + 1 >= mPer[0]) found = 1;
      end
      checks++; if (found == 0) begin failures++; $display("[TB] FAIL halt.noevent got=0 exp=1"); end
      frozenA = period[0];
      defeat = 1'b1;
      @(negedge clk);
      defeat = 1'b0;
      checks++; if (motion[0] !== 3'd0) begin failures++; $display("[TB] FAIL halt.motion got=%0d exp=0", motion[0]); end
      checks++; if (halted[0] !== 1'b1) begin failures++; $display("[TB] FAIL halt.halted got=%0b exp=1", halted[0]); end
      for (int c = 1; c <= 25; c++) begin
         applyStimulus(1, $urandom % 2, $urandom % 2, ($urandom % 2) == 1, 0, 0);
         @(negedge clk);
         checks++; if (period[0] !== frozenA) begin failures++; $display("[TB] FAIL halt.period cyc%0d got=%0d exp=%0d", c, period[0], frozenA); end
         for (int i = 0; i < 2; i++) begin
            checks++; if (motion[i] !== 3'd0 || halted[i] !== 1'b1) begin failures++; $display("[TB] FAIL halt.frozen dut%0d got=%0d/%0b exp=0/1", i, motion[i], halted[i]); end
         end
      end
   endtask

   task automatic test_async_reset();
      int firstStep = -1;
      applyReset();
      applyStimulus(1, 1, 1, 1, 0, 0);
      @(negedge clk);
      killingAlien = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++; if (period[i] !== 8'(pInit[i])) begin failures++; $display("[TB] FAIL async.period dut%0d got=%0d exp=%0d", i, period[i], pInit[i]); end
         checks++; if (motion[i] !== 3'd0 || halted[i] !== 1'b0) begin failures++; $display("[TB] FAIL async.outputs dut%0d got=%0d/%0b exp=0/0", i, motion[i], halted[i]); end
      end
      @(negedge clk);
      reset = 1'b1;
      for (int c = 1; c <= 20 && firstStep < 0; c++) begin
         @(negedge clk);
         if (motion[0] == 3'd2) firstStep = c;
      end
      checks++; if (firstStep != 6) begin failures++; $display("[TB] FAIL async.firststep got=%0d exp=6", firstStep); end
   endtask

   initial begin
      $display("[TB] starting alien_zigzag_ctrl bench");
      test_reset();
      test_march();
      test_wall_descend();
      test_both_walls();
      test_kills();
      test_random();
      test_halt();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
